// File: rtl/pinorder_pkg.sv
// Shared types and constants for the foo-style pin bundle source.
//   src_state_t : replay FSM states
//   pin_word_t  : one bundle word {y, x, abc, def}
//   idle_word() : the word driven whenever no word is active
package pinorder_pkg;

  localparam int X_W   = 8;
  localparam int ABC_W = 3;
  localparam int DEF_W = 32;

  localparam logic [DEF_W-1:0] DEF_IDLE = 32'h1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } src_state_t;

  typedef struct packed {
    logic             y;
    logic [X_W-1:0]   x;
    logic [ABC_W-1:0] abc;
    logic [DEF_W-1:0] def;
  } pin_word_t;

  function automatic pin_word_t idle_word(input logic [DEF_W-1:0] def_idle);
    pin_word_t w;
    w     = '0;
    w.def = def_idle;
    return w;
  endfunction

endpackage

// File: rtl/pinorder_fifo.sv
// DEPTH-entry synchronous FIFO of pin_word_t.
// Ports:
//   clk, reset_l      : clock, async active-low reset
//   push, wr_data     : write request (ignored while full, even with a pop)
//   pop, rd_data      : read request (ignored while empty), head word
//   full, empty       : occupancy flags from the registered level
//   nonempty_q        : not-empty flag delayed by one cycle
//   level             : current occupancy
module pinorder_fifo
  import pinorder_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          push,
  input  pin_word_t     wr_data,
  input  logic          pop,
  output pin_word_t     rd_data,
  output logic          full,
  output logic          empty,
  output logic          nonempty_q,
  output logic [LW-1:0] level
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ne_q, ne_d;
  logic          push_ok, pop_ok;
  pin_word_t     mem_q [DEPTH];

  assign full       = (level_q == LW'(DEPTH));
  assign empty      = (level_q == '0);
  assign level      = level_q;
  assign nonempty_q = ne_q;
  assign rd_data    = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ne_d     = !empty;
    // DEPTH is a power of two, so pointers wrap by plain overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ne_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ne_q     <= ne_d;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/pinorder_src.sv
// Source-side driver for the foo-style pin bundle.
// Words arrive over in_valid/in_ready into a FIFO, then each is replayed on
// registered pins for max(hold_cycles,1) cycles, followed by GAP_CYC idle
// cycles.
// Ports:
//   clk, reset_l                       : clock, async active-low reset
//   in_valid/in_ready, in_y..in_def    : word input port
//   hold_cycles                        : drive length, sampled at word load
//   y, x, abcconst, def                : driven pins (idle values otherwise)
//   drv_valid                          : pins carry a word
//   done                               : last drive cycle of a word
//   level                              : FIFO occupancy
module pinorder_src #(
  parameter int          DEPTH    = 4,
  parameter int          HOLD_W   = 4,
  parameter int          GAP_CYC  = 1,
  parameter logic [31:0] DEF_IDLE = pinorder_pkg::DEF_IDLE
) (
  input  logic                     clk,
  input  logic                     reset_l,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_y,
  input  logic [7:0]               in_x,
  input  logic [2:0]               in_abc,
  input  logic [31:0]              in_def,
  input  logic [HOLD_W-1:0]        hold_cycles,
  output logic                     y,
  output logic [7:0]               x,
  output logic [2:0]               abcconst,
  output logic [31:0]              def,
  output logic                     drv_valid,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level
);

  import pinorder_pkg::*;

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

  src_state_t        state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_eff;
  logic [GW-1:0]     gap_q, gap_d;
  pin_word_t         word_q, word_d;
  logic              drv_valid_q, drv_valid_d;
  pin_word_t         fifo_wr, fifo_rd;
  logic              fifo_full, fifo_empty, fifo_ne_q;
  logic              avail, load;

  assign fifo_wr  = '{y: in_y, x: in_x, abc: in_abc, def: in_def};
  assign in_ready = !fifo_full;

  pinorder_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset_l    (reset_l),
    .push       (in_valid),
    .wr_data    (fifo_wr),
    .pop        (load),
    .rd_data    (fifo_rd),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .nonempty_q (fifo_ne_q),
    .level      (level)
  );

  // The delayed not-empty flag sets the two-edge load latency; the live
  // empty flag keeps a just-drained FIFO from being popped again.
  assign avail = fifo_ne_q && !fifo_empty;

  always_comb begin
    hold_eff    = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
    state_d     = state_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    word_d      = word_q;
    drv_valid_d = drv_valid_q;
    load        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (avail) load = 1'b1;
      end
      DRIVE: begin
        if (cnt_q > HOLD_W'(1)) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else if (GAP_CYC > 0) begin
          state_d     = GAP;
          gap_d       = GW'(GAP_CYC);
          word_d      = idle_word(DEF_IDLE);
          drv_valid_d = 1'b0;
        end else if (avail) begin
          load = 1'b1;
        end else begin
          state_d     = IDLE;
          word_d      = idle_word(DEF_IDLE);
          drv_valid_d = 1'b0;
        end
      end
      GAP: begin
        // Loading straight out of the last gap cycle keeps the inter-word
        // gap at exactly GAP_CYC instead of adding an IDLE bubble.
        if (gap_q > GW'(1)) begin
          gap_d = gap_q - GW'(1);
        end else if (avail) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        word_d      = idle_word(DEF_IDLE);
        drv_valid_d = 1'b0;
      end
    endcase
    if (load) begin
      state_d     = DRIVE;
      cnt_d       = hold_eff;
      word_d      = fifo_rd;
      drv_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      word_q      <= idle_word(DEF_IDLE);
      drv_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      word_q      <= word_d;
      drv_valid_q <= drv_valid_d;
    end
  end

  assign y         = word_q.y;
  assign x         = word_q.x;
  assign abcconst  = word_q.abc;
  assign def       = word_q.def;
  assign drv_valid = drv_valid_q;
  assign done      = (state_q == DRIVE) && (cnt_q == HOLD_W'(1));

endmodule
